cpu_tick_gen: RTL and testbench

- Parametrised clock-enable generator for the trainer CPU.
- Divides the single system clock by a programmable ratio and produces a one-cycle `cpu_en` strobe for the CPU core, so the core runs on the system clock with an enable instead of a derived clock.
- Adds halt, run and single-step control, a wrapping strobe counter, and PWM-dimmed, active-low status LEDs that display low strobe-counter bits.
- Sits between the oscillator and the CPU core inside the top level.

---
 rtl/cpu_tick_gen.sv | 98 +++++++++
 tb/tb_cpu_tick_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_tick_gen.sv
// cpu_tick_gen: divides the system clock into a one-cycle CPU enable strobe.
// Single-step support is compiled in only when CPU_TICK_GEN_STEP_EN is defined.
module cpu_tick_gen #(
  parameter int DIV_W    = 24,
  parameter int CNT_W    = 16,
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DIV_W-1:0]    i_div_val,
  input  logic [1:0]          i_mode,
  input  logic                i_step_req,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_cpu_en,
  output logic [CNT_W-1:0]    o_tick_count,
  output logic [CHANNELS-1:0] o_led_n
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [DIV_W-1:0]    r_cnt;
  logic                r_cpu_en;
  logic [CNT_W-1:0]    r_tick_count;
  logic [PWM_BITS-1:0] r_pwm;
  logic [CHANNELS-1:0] r_led_n;

  logic w_tick;
  logic w_run;
  logic w_fire;
  logic w_pwm_on;

  assign w_tick   = (r_cnt == '0);
  assign w_run    = (i_mode == MODE_RUN);
  assign w_pwm_on = (r_pwm < i_duty);

`ifdef CPU_TICK_GEN_STEP_EN
  logic r_pend;
  logic w_step;

  assign w_step = (i_mode == MODE_STEP);
  assign w_fire = w_tick & (w_run | (w_step & r_pend));

  // A new request outranks the clear so it is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
    end else if (!w_step) begin
      r_pend <= 1'b0;
    end else if (i_step_req) begin
      r_pend <= 1'b1;
    end else if (w_fire) begin
      r_pend <= 1'b0;
    end
  end
`else
  logic w_unused_step;

  assign w_unused_step = i_step_req;
  assign w_fire        = w_tick & w_run;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || w_tick) begin
      r_cnt <= i_div_val;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_en     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_cpu_en <= w_fire;
      if (r_cpu_en) begin
        r_tick_count <= r_tick_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm   <= '0;
      r_led_n <= '1;
    end else begin
      r_pwm   <= r_pwm + PWM_BITS'(1);
      r_led_n <= ~(r_tick_count[CHANNELS-1:0] & {CHANNELS{w_pwm_on}});
    end
  end

  assign o_cpu_en     = r_cpu_en;
  assign o_tick_count = r_tick_count;
  assign o_led_n      = r_led_n;

endmodule

// File: tb/tb_cpu_tick_gen.sv
// tb_cpu_tick_gen: scoreboard bench for the CPU clock-enable generator.
// Expected strobe edges are queued at stimulus time and matched on output.
module tb_cpu_tick_gen;

  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  logic        clk;
  logic        rst;
  logic [23:0] div_val;
  logic [1:0]  mode;
  logic        step_req;
  logic [7:0]  duty;
  logic        cpu_en;
  logic [15:0] tick_count;
  logic [2:0]  led_n;

  int total;
  int bad;
  int q_exp[$];

  cpu_tick_gen dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_div_val    (div_val),
    .i_mode       (mode),
    .i_step_req   (step_req),
    .i_duty       (duty),
    .o_cpu_en     (cpu_en),
    .o_tick_count (tick_count),
    .o_led_n      (led_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [23:0] d, input logic [1:0] m);
    rst      = 1'b1;
    div_val  = d;
    mode     = m;
    step_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    duty = 8'd255;
    do_reset(24'd3, M_RUN);
    total++;
    if (cpu_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_cpu_en got=%b want=0", cpu_en);
    end
    total++;
    if (tick_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", tick_count);
    end
    total++;
    if (led_n !== 3'b111) begin
      bad++;
      $display("FAIL reset_led got=%b want=111", led_n);
    end
  endtask

  task automatic test_run();
    int exp;
    do_reset(24'd3, M_RUN);
    q_exp.push_back(4);
    q_exp.push_back(8);
    q_exp.push_back(12);
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (cpu_en === 1'b1) begin
        total++;
        if (q_exp.size() == 0) begin
          bad++;
          $display("FAIL run_extra got_edge=%0d want=none", e);
        end else begin
          exp = q_exp.pop_front();
          if (e !== exp) begin
            bad++;
            $display("FAIL run_edge got=%0d want=%0d", e, exp);
          end
        end
      end
    end
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL run_missing got=%0d left want=0", q_exp.size());
    end
    q_exp.delete();
    total++;
    if (tick_count !== 16'd3) begin
      bad++;
      $display("FAIL run_count got=%0d want=3", tick_count);
    end
  endtask

  task automatic test_d0();
    int exp;
    do_reset(24'd0, M_RUN);
    for (int e = 1; e <= 11; e++) begin
      q_exp.push_back(e - 1);
      tick();
      exp = q_exp.pop_front();
      total++;
      if (cpu_en !== 1'b1 || tick_count !== 16'(exp)) begin
        bad++;
        $display("FAIL d0_edge%0d got en=%b cnt=%0d want en=1 cnt=%0d",
                 e, cpu_en, tick_count, exp);
      end
    end
  endtask

  task automatic test_step();
    int exp;
    int want_cnt;
    do_reset(24'd4, M_STEP);
`ifdef CPU_TICK_GEN_STEP_EN
    q_exp.push_back(10);
    q_exp.push_back(25);
    want_cnt = 2;
`else
    want_cnt = 0;
`endif
    for (int e = 1; e <= 28; e++) begin
      step_req = (e == 6 || e == 7 || e == 9 || e == 20);
      tick();
      if (cpu_en === 1'b1) begin
        total++;
        if (q_exp.size() == 0) begin
          bad++;
          $display("FAIL step_extra got_edge=%0d want=none", e);
        end else begin
          exp = q_exp.pop_front();
          if (e !== exp) begin
            bad++;
            $display("FAIL step_edge got=%0d want=%0d", e, exp);
          end
        end
      end
    end
    step_req = 1'b0;
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL step_missing got=%0d left want=0", q_exp.size());
    end
    q_exp.delete();
    total++;
    if (tick_count !== 16'(want_cnt)) begin
      bad++;
      $display("FAIL step_count got=%0d want=%0d", tick_count, want_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int exp;
    duty = 8'd255;
    do_reset(24'd4, M_RUN);
    q_exp.push_back(5);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (cpu_en === 1'b1) begin
        total++;
        exp = (q_exp.size() != 0) ? q_exp.pop_front() : -1;
        if (e !== exp) begin
          bad++;
          $display("FAIL mid_pre_edge got=%0d want=%0d", e, exp);
        end
      end
    end
    total++;
    if (tick_count !== 16'd1 || led_n !== 3'b110) begin
      bad++;
      $display("FAIL mid_pre_state got cnt=%0d led=%b want cnt=1 led=110",
               tick_count, led_n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (cpu_en !== 1'b0 || tick_count !== 16'd0 || led_n !== 3'b111) begin
      bad++;
      $display("FAIL mid_reset got en=%b cnt=%0d led=%b want 0 0 111",
               cpu_en, tick_count, led_n);
    end
    q_exp.delete();
    q_exp.push_back(5);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (cpu_en === 1'b1) begin
        total++;
        exp = (q_exp.size() != 0) ? q_exp.pop_front() : -1;
        if (e !== exp) begin
          bad++;
          $display("FAIL mid_post_edge got=%0d want=%0d", e, exp);
        end
      end
    end
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL mid_post_missing got=%0d left want=0", q_exp.size());
    end
    q_exp.delete();
    // pending step must be discarded by reset
    do_reset(24'd4, M_STEP);
    for (int e = 1; e <= 20; e++) begin
      step_req = (e == 7);
      rst      = (e == 8);
      tick();
      if (e > 8 && cpu_en === 1'b1) begin
        total++;
        bad++;
        $display("FAIL pend_discard got strobe at edge=%0d want=none", e);
      end
    end
    rst      = 1'b0;
    step_req = 1'b0;
    total++;
    if (tick_count !== 16'd0) begin
      bad++;
      $display("FAIL pend_discard_cnt got=%0d want=0", tick_count);
    end
  endtask

  task automatic test_pwm();
    int nlit;
    int low0;
    int hi12;
    duty = 8'd0;
    do_reset(24'd0, M_RUN);
    tick();
    mode = M_HALT;
    tick();
    total++;
    if (tick_count !== 16'd1) begin
      bad++;
      $display("FAIL pwm_count got=%0d want=1", tick_count);
    end
    nlit = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led_n !== 3'b111) nlit++;
    end
    total++;
    if (nlit != 0) begin
      bad++;
      $display("FAIL pwm_duty0 got=%0d lit want=0", nlit);
    end
    duty = 8'd128;
    tick();
    tick();
    low0 = 0;
    hi12 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led_n[0] === 1'b0) low0++;
      if (led_n[2:1] !== 2'b11) hi12++;
    end
    total++;
    if (low0 != 128) begin
      bad++;
      $display("FAIL pwm_duty128_led0 got=%0d want=128", low0);
    end
    total++;
    if (hi12 != 0) begin
      bad++;
      $display("FAIL pwm_duty128_led21 got=%0d lit want=0", hi12);
    end
    duty = 8'd255;
    tick();
    tick();
    low0 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led_n[0] === 1'b0) low0++;
    end
    total++;
    if (low0 != 255) begin
      bad++;
      $display("FAIL pwm_duty255_led0 got=%0d want=255", low0);
    end
  endtask

  task automatic test_wrap();
    duty = 8'd255;
    do_reset(24'd0, M_RUN);
    for (int e = 1; e <= 65536; e++) tick();
    total++;
    if (tick_count !== 16'hFFFF || cpu_en !== 1'b1) begin
      bad++;
      $display("FAIL wrap_top got cnt=%h en=%b want ffff 1", tick_count, cpu_en);
    end
    mode = M_HALT;
    tick();
    total++;
    if (tick_count !== 16'h0000 || cpu_en !== 1'b0 || led_n !== 3'b000) begin
      bad++;
      $display("FAIL wrap_zero got cnt=%h en=%b led=%b want 0000 0 000",
               tick_count, cpu_en, led_n);
    end
    tick();
    total++;
    if (led_n !== 3'b111 || tick_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_led got led=%b cnt=%h want 111 0000", led_n, tick_count);
    end
  endtask

  task automatic test_mode3();
    do_reset(24'd2, 2'b11);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (cpu_en === 1'b1) begin
        total++;
        bad++;
        $display("FAIL mode3 got strobe at edge=%0d want=none", e);
      end
    end
    mode = M_RUN;
    for (int e = 13; e <= 15; e++) tick();
    total++;
    if (cpu_en !== 1'b1) begin
      bad++;
      $display("FAIL mode3_to_run got en=%b want=1", cpu_en);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    div_val  = '0;
    mode     = M_HALT;
    step_req = 1'b0;
    duty     = '0;
    test_reset();
    test_run();
    test_d0();
    test_step();
    test_mid_reset();
    test_mode3();
    test_pwm();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
